imem_loader: RTL
================

Name: imem_loader

Overview:
- Writer side of the byte-addressed instruction memory. The fetch path reads this memory as little-endian words: {im[PC+3], im[PC+2], im[PC+1], im[PC]}.
- Accepts a program as a stream of bytes over a valid/ready handshake and issues one byte write per accepted byte into the instruction memory's write port.
- Holds the core stalled while loading. Reports completion and errors.
- Sits between the external boot/debug byte source and the instruction memory write port.

Parameters:
- ADDR_W, 12, instruction memory byte-address width (4096 bytes).
- BASE_ADDR, 0, first byte address written. Must be a multiple of 4.
- LEN_W, 11, width of the word-count input. Must be able to hold the capacity value.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle load request; sampled in IDLE only.
- len_words  input  LEN_W  number of 32-bit words to load; latched on start.
- abort  input  1  synchronous abort of an in-progress load.
- in_valid  input  1  byte source has data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  byte write enable to instruction memory.
- mem_addr  output  ADDR_W  byte write address.
- mem_wdata  output  8  byte write data.
- busy  output  1  high whenever state is not IDLE.
- core_stall  output  1  stall/hold for the fetch stage; equals busy.
- done  output  1  one-cycle pulse at load completion.
- err  output  1  sticky error flag; cleared on the next accepted start.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, byte counter=0.
  - in_ready, mem_we, mem_addr, mem_wdata, busy, core_stall, done, err all 0.
  - Memory contents are not touched; bytes already written by an interrupted load remain.
- States: IDLE, LOAD, CHECK (only with the optional feature), DONE.
- IDLE:
  - in_ready=0.
  - On start=1: latch len_words, compute total = len_words*4, clear err.
  - If len_words==0: go to DONE.
  - If len_words > capacity, where capacity = (2^ADDR_W − BASE_ADDR)/4: set err=1, go to DONE. No writes are issued.
  - Otherwise: go to LOAD with counter=0.
- LOAD:
  - in_ready=1 combinationally.
  - A transfer occurs when in_valid & in_ready.
  - Per transfer at byte index k: in the next cycle mem_we=1, mem_addr=BASE_ADDR+k, mem_wdata=that byte. This is registered, 1-cycle latency, and mem_we is high for exactly one cycle.
  - Counter increments per transfer.
  - Bytes are written in stream order, so byte 4n+i lands at BASE_ADDR+4n+i (little-endian words).
  - in_valid=0 cycles stall the load with no writes and no timeout.
  - On the transfer of byte total−1: go to DONE (or CHECK when the feature is enabled).
- DONE:
  - done=1 for exactly one cycle; this is the same cycle as the final mem_we.
  - Next state IDLE; busy drops in that IDLE cycle.
- abort=1 in LOAD/CHECK:
  - Next cycle state=IDLE and err=1; no done pulse.
  - A write already registered for a byte accepted in the abort cycle still completes.
  - abort has priority over a simultaneous transfer of the last byte.
- start while busy is ignored, as is abort in IDLE/DONE.
- Address arithmetic is ADDR_W bits. The capacity check guarantees no wrap-around, so mem_addr never exceeds 2^ADDR_W−1.
- mem_addr and mem_wdata hold their last value when mem_we=0.
- core_stall=busy. The fetch stage must not read while core_stall=1.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last data byte, state CHECK. in_ready=1 and one extra byte is accepted; it is not written to memory (mem_we stays 0).
  - That byte is compared with the running XOR of all data bytes of this load. On mismatch, err=1.
  - Then go to DONE, and done pulses regardless of the result.
  - For len_words==0, the expected checksum is 0x00 and one byte is still consumed.
- Not defined: CHECK state and XOR logic are absent, and LOAD goes directly to DONE.

Test Plan:
- Basic load:
  - Stimulus: reset, start with len_words=2, stream 13 06 50 00 93 66 B0 00 with in_valid held high.
  - Response: writes to addr 0..7 with those bytes on consecutive cycles; done=1 in the same cycle as the addr-7 write; err=0; busy=0 the next cycle.
- Source stalls:
  - Stimulus: len_words=1, in_valid toggled 1,0,0,1,1,0,1.
  - Response: exactly 4 writes at addr 0..3 in stream order; no mem_we in gap cycles.
- Zero and overflow lengths:
  - Stimulus A: len_words=0. Response: done the cycle after start, no mem_we, err=0.
  - Stimulus B: len_words=1025. Response: done with err=1, no mem_we.
- Abort and reset:
  - Stimulus A: abort after byte 5 of an 8-byte load. Response: writes for bytes 0..5 only, no done, err=1.
  - Stimulus B: rst_n low mid-load. Response: all outputs 0 asynchronously.
- Start while busy:
  - Stimulus: pulse start with len_words=3 during a load with len_words=1.
  - Response: ignored; only 4 writes; err stays 0 after the load.
- Checksum (IMEM_LOADER_CHECKSUM_EN):
  - Stimulus A: len_words=1, bytes 01 02 04 08, checksum 0F. Response: err=0, 4 writes.
  - Stimulus B: same load with checksum 0E. Response: err=1, done still pulses.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte stream in / instruction-memory byte write out, as seen by imem_loader.
//
// Stream handshake: a byte moves on a rising clk edge where in_valid and
// in_ready are both high. The source may raise in_valid at any time and
// must hold in_data stable while in_valid is high and in_ready is low.
// in_ready depends only on loader state, never on in_valid.
// Write port: mem_we is a single-cycle strobe; mem_addr/mem_wdata hold their
// last value while mem_we is low.
interface imem_loader_if #(
  parameter int ADDR_W = 12
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  // Byte source plus memory observer (boot/debug side, testbench).
  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  // The loader itself.
  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: writes a byte stream into the instruction memory starting at
// BASE_ADDR, one byte write per accepted byte, while stalling the core.
// Byte 4n+i lands at BASE_ADDR+4n+i, so fetch sees little-endian words.
// Optional macro IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
// that is consumed (not written) and compared against the data bytes.
module imem_loader #(
  parameter int ADDR_W    = 12,
  parameter int BASE_ADDR = 0,
  parameter int LEN_W     = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len_words,
  input  logic             abort,
  imem_loader_if.slave     bus,
  output logic             busy,
  output logic             core_stall,
  output logic             done,
  output logic             err,
  output logic [1:0]       dbg_state
);

  // Words that fit between BASE_ADDR and the top of memory.
  localparam int unsigned CAPACITY = ((1 << ADDR_W) - BASE_ADDR) / 4;
  // Byte counter wide enough for len_words*4.
  localparam int CNT_W = LEN_W + 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CHECK = 2'd3
`endif
  } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  // After the last data byte (or straight away for an empty load) the
  // checksum byte still has to be consumed.
  localparam state_t DATA_END  = S_CHECK;
  localparam state_t EMPTY_END = S_CHECK;
`else
  localparam state_t DATA_END  = S_DONE;
  localparam state_t EMPTY_END = S_DONE;
`endif

  state_t            state, state_nxt;
  logic              ready_c;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  total;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic              err_q;
  logic              xfer;
  logic              last_byte;
  logic              len_zero;
  logic              len_over;
  logic              accept_start;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  assign xfer         = (state == S_LOAD) && bus.in_valid;
  assign last_byte    = (count == total - CNT_W'(1));
  assign len_zero     = (len_words == '0);
  assign len_over     = (32'(len_words) > CAPACITY);
  assign accept_start = (state == S_IDLE) && start;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state and stream ready; abort wins over a final-byte transfer.
  always_comb begin
    state_nxt = state;
    ready_c   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (len_over)      state_nxt = S_DONE;
          else if (len_zero) state_nxt = EMPTY_END;
          else               state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        ready_c = 1'b1;
        if (abort)                          state_nxt = S_IDLE;
        else if (bus.in_valid && last_byte) state_nxt = DATA_END;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        ready_c = 1'b1;
        if (abort)             state_nxt = S_IDLE;
        else if (bus.in_valid) state_nxt = S_DONE;
      end
`endif
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Load bookkeeping: length latch, byte counter and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      total <= '0;
      err_q <= 1'b0;
    end else begin
      if (accept_start) begin
        count <= '0;
        total <= {len_words, 2'b00};
        err_q <= len_over;
      end else if (xfer) begin
        count <= count + CNT_W'(1);
      end
      if (abort && (state == S_LOAD)) err_q <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      if ((state == S_CHECK) && (abort || (bus.in_valid && (bus.in_data != csum_q))))
        err_q <= 1'b1;
`endif
    end
  end

  // Registered byte write, one cycle after acceptance; address/data hold
  // between writes. A byte taken in an abort cycle is still written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= xfer;
      if (xfer) begin
        addr_q  <= ADDR_W'(BASE_ADDR) + ADDR_W'(count);
        wdata_q <= bus.in_data;
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running XOR of this load's data bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            csum_q <= '0;
    else if (accept_start) csum_q <= '0;
    else if (xfer)         csum_q <= csum_q ^ bus.in_data;
  end
`endif

  assign bus.in_ready  = ready_c;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign busy          = (state != S_IDLE);
  assign core_stall    = busy;
  assign done          = (state == S_DONE);
  assign err           = err_q;
  assign dbg_state     = state;

endmodule
